// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four valid/ready sources, the round-robin arbiter and its consumer.
// The packet-lock signals exist only when MUX4_RR_ARBITER_PKT_LOCK_EN is defined.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       sel;
`ifdef MUX4_RR_ARBITER_PKT_LOCK_EN
  logic [3:0]       in_last;
  logic             out_last;

  modport slave (
    input  in0, in1, in2, in3, in_valid, in_last, out_ready,
    output in_ready, out, out_valid, sel, out_last
  );

  modport master (
    output in0, in1, in2, in3, in_valid, in_last, out_ready,
    input  in_ready, out, out_valid, sel, out_last
  );
`else
  modport slave (
    input  in0, in1, in2, in3, in_valid, out_ready,
    output in_ready, out, out_valid, sel
  );

  modport master (
    output in0, in1, in2, in3, in_valid, out_ready,
    input  in_ready, out, out_valid, sel
  );
`endif
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Four-source round-robin arbiter feeding a registered 4:1 output stage (one beat per cycle).
// Define MUX4_RR_ARBITER_PKT_LOCK_EN to hold the grant on one source until its in_last beat.
module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mux4_rr_arbiter_if.slave bus
);

  logic [1:0]       ptr;
  logic [1:0]       rr_win;
  logic [1:0]       win;
  logic             gnt_any;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] out_p1;
  logic [1:0]       sel_p1;
  logic             vld_p1;

  // Nearest requester after p wins; p itself is searched last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] c;
    w = p;
    for (int k = 4; k >= 1; k--) begin
      c = p + 2'(k);
      if (req[c]) w = c;
    end
    return w;
  endfunction

  assign load   = ~vld_p1 | bus.out_ready;
  assign rr_win = rr_pick(bus.in_valid, ptr);

`ifdef MUX4_RR_ARBITER_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] lk;
  logic [1:0] lk_nxt;
  logic       last_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lk    <= 2'd0;
    end else begin
      state <= state_nxt;
      lk    <= lk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lk_nxt    = lk;
    win       = rr_win;
    gnt_any   = |bus.in_valid;
    if (state == LOCKED) begin
      win     = lk;
      gnt_any = bus.in_valid[lk];
    end
    xfer = rst_n & load & gnt_any;
    case (state)
      IDLE: begin
        if (xfer && !bus.in_last[win]) begin
          state_nxt = LOCKED;
          lk_nxt    = win;
        end
      end
      LOCKED: begin
        if (xfer && bus.in_last[lk]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_p1 <= 1'b0;
    end else if (load && gnt_any) begin
      last_p1 <= bus.in_last[win];
    end
  end

  assign bus.out_last = last_p1;
`else
  assign win     = rr_win;
  assign gnt_any = |bus.in_valid;
  assign xfer    = rst_n & load & gnt_any;
`endif

  assign bus.in_ready = xfer ? (4'b0001 << win) : 4'b0000;

  always_comb begin
    mux_d = bus.in0;
    case (win)
      2'd0: mux_d = bus.in0;
      2'd1: mux_d = bus.in1;
      2'd2: mux_d = bus.in2;
      2'd3: mux_d = bus.in3;
      default: mux_d = bus.in0;
    endcase
  end

  // Output stage: refills on the same edge it drains, so no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      out_p1 <= '0;
      sel_p1 <= 2'd0;
      ptr    <= 2'd3;
    end else if (load) begin
      vld_p1 <= gnt_any;
      if (gnt_any) begin
        out_p1 <= mux_d;
        sel_p1 <= win;
        ptr    <= win;
      end
    end
  end

  assign bus.out       = out_p1;
  assign bus.out_valid = vld_p1;
  assign bus.sel       = sel_p1;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Table-driven bench for mux4_rr_arbiter; granted beats are queued when driven and checked at the output.
// Exercises the packet-lock path too when MUX4_RR_ARBITER_PKT_LOCK_EN is defined.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst_n;

  mux4_rr_arbiter_if #(.WIDTH(8)) bus ();

  mux4_rr_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] il;
    logic [3:0] ir;
    logic       ov;
    logic       push;
    logic [1:0] psel;
    logic       plast;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int    tests = 0;
  int    fails = 0;
  vec_t  tbl[20];

  function automatic vec_t mk(input logic [3:0] iv, input logic ordy, input logic [3:0] il,
                              input logic [3:0] ir, input logic ov, input logic push,
                              input logic [1:0] psel, input logic plast);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.il = il; v.ir = ir;
    v.ov = ov; v.push = push; v.psel = psel; v.plast = plast;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    beat_t b;
    @(negedge clk);
    bus.in_valid  = v.iv;
    bus.out_ready = v.ordy;
`ifdef MUX4_RR_ARBITER_PKT_LOCK_EN
    bus.in_last   = v.il;
`endif
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(v.ir));
    check("out_valid", 32'(bus.out_valid), 32'(v.ov));
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got beat sel=%0d out=%0h expected none", bus.sel, bus.out);
      end else begin
        check("out_sel", 32'(bus.sel), 32'(sb[0].sel));
        check("out_data", 32'(bus.out), 32'(sb[0].data));
`ifdef MUX4_RR_ARBITER_PKT_LOCK_EN
        check("out_last", 32'(bus.out_last), 32'(sb[0].last));
`endif
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
    if (v.push) begin
      b.sel  = v.psel;
      b.data = 8'h10 + {6'd0, v.psel};
      b.last = v.plast;
      sb.push_back(b);
    end
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // round robin, backpressure, idle-to-wrap, then idle hold
    tbl[0]  = mk(4'hF, 1, 4'hF, 4'b0001, 0, 1, 2'd0, 1);
    tbl[1]  = mk(4'hF, 1, 4'hF, 4'b0010, 1, 1, 2'd1, 1);
    tbl[2]  = mk(4'hF, 1, 4'hF, 4'b0100, 1, 1, 2'd2, 1);
    tbl[3]  = mk(4'hF, 1, 4'hF, 4'b1000, 1, 1, 2'd3, 1);
    tbl[4]  = mk(4'hF, 1, 4'hF, 4'b0001, 1, 1, 2'd0, 1);
    tbl[5]  = mk(4'hF, 1, 4'hF, 4'b0010, 1, 1, 2'd1, 1);
    tbl[6]  = mk(4'hF, 0, 4'hF, 4'b0000, 1, 0, 2'd0, 1);
    tbl[7]  = mk(4'hF, 0, 4'hF, 4'b0000, 1, 0, 2'd0, 1);
    tbl[8]  = mk(4'hF, 0, 4'hF, 4'b0000, 1, 0, 2'd0, 1);
    tbl[9]  = mk(4'hF, 1, 4'hF, 4'b0100, 1, 1, 2'd2, 1);
    tbl[10] = mk(4'h0, 1, 4'hF, 4'b0000, 1, 0, 2'd0, 1);
    tbl[11] = mk(4'h4, 1, 4'hF, 4'b0100, 0, 1, 2'd2, 1);
    tbl[12] = mk(4'h4, 1, 4'hF, 4'b0100, 1, 1, 2'd2, 1);
    tbl[13] = mk(4'h6, 1, 4'hF, 4'b0010, 1, 1, 2'd1, 1);
    tbl[14] = mk(4'h6, 1, 4'hF, 4'b0100, 1, 1, 2'd2, 1);
    tbl[15] = mk(4'h8, 1, 4'hF, 4'b1000, 1, 1, 2'd3, 1);
    tbl[16] = mk(4'h0, 1, 4'hF, 4'b0000, 1, 0, 2'd0, 1);
    tbl[17] = mk(4'h0, 1, 4'hF, 4'b0000, 0, 0, 2'd0, 1);
    tbl[18] = mk(4'h9, 1, 4'hF, 4'b0001, 0, 1, 2'd0, 1);
    tbl[19] = mk(4'h0, 1, 4'hF, 4'b0000, 1, 0, 2'd0, 1);

    bus.in0 = 8'h10;
    bus.in1 = 8'h11;
    bus.in2 = 8'h12;
    bus.in3 = 8'h13;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
`ifdef MUX4_RR_ARBITER_PKT_LOCK_EN
    bus.in_last   = 4'hF;
`endif
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    bus.in_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply_vec(tbl[i]);
      if (i == 17) begin
        check("idle_hold_out", 32'(bus.out), 32'h13);
        check("idle_hold_sel", 32'(bus.sel), 32'd3);
      end
    end
    check_drained("drain_main");

    // asynchronous reset while a beat is held in the output stage
    apply_vec(mk(4'hF, 1, 4'hF, 4'b0010, 0, 1, 2'd1, 1));
    apply_vec(mk(4'hF, 0, 4'hF, 4'b0000, 1, 0, 2'd0, 1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_out", 32'(bus.out), 32'd0);
    check("async_rst_sel", 32'(bus.sel), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
    sb.delete();
    bus.in_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec(mk(4'hF, 1, 4'hF, 4'b0001, 0, 1, 2'd0, 1));
    apply_vec(mk(4'h0, 1, 4'hF, 4'b0000, 1, 0, 2'd0, 1));
    check_drained("drain_reset");

`ifdef MUX4_RR_ARBITER_PKT_LOCK_EN
    // in1 sends a 3-beat packet while in0 and in2 compete
    apply_vec(mk(4'h7, 1, 4'b1101, 4'b0010, 0, 1, 2'd1, 0));
    apply_vec(mk(4'h7, 1, 4'b1101, 4'b0010, 1, 1, 2'd1, 0));
    apply_vec(mk(4'h7, 1, 4'b1111, 4'b0010, 1, 1, 2'd1, 1));
    apply_vec(mk(4'h7, 1, 4'b1111, 4'b0100, 1, 1, 2'd2, 1));
    apply_vec(mk(4'h0, 1, 4'b1111, 4'b0000, 1, 0, 2'd0, 1));
    check_drained("drain_lock");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Four-input round-robin arbiter with a registered output stage, on the input side of the datapath.
- Selects one of four valid/ready sources (in0..in3) each cycle and drives the shared 4:1 data path.
- Registers the winning beat and exports the winner index as sel for downstream steering and debug.
- Sustains one beat per cycle and is fair across requesters.

Parameters:
- WIDTH, 8, data width of each input and of out

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in0  input  WIDTH  source 0 data
- in1  input  WIDTH  source 1 data
- in2  input  WIDTH  source 2 data
- in3  input  WIDTH  source 3 data
- in_valid  input  4  per-source valid, bit i for in<i>
- in_ready  output  4  per-source ready, at most one bit high
- out  output  WIDTH  registered granted data
- out_valid  output  1  out holds a beat
- out_ready  input  1  downstream accepts out this cycle
- sel  output  2  source index of the beat currently in out

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out=0, sel=0.
  - Priority pointer ptr=3, so in0 has top priority after reset.
  - in_ready=0 while in reset.
  - Beats in flight are discarded.
- load = ~out_valid | out_ready. This is the output register free/draining condition.
- Grant (combinational):
  - Winner is the first set bit of in_valid, searching indices ptr+1, ptr+2, ptr+3, ptr (mod 4 wrap).
  - gnt_any = |in_valid.
- in_ready[i] = load & gnt_any & (winner==i). At most one bit is high.
- Sources must not make in_valid depend on in_ready.
- Transfer on source i (in_valid[i] & in_ready[i]):
  - Next edge: out<=in<i>, out_valid<=1, sel<=i, ptr<=i.
- load=1 with no valid input: out_valid<=0; out and sel hold their last value.
- Stall, out_valid=1 & out_ready=0:
  - out, sel and out_valid hold.
  - All in_ready are 0.
  - ptr holds.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle while out_ready=1. There is no bubble on simultaneous drain and load.
- Fairness: an input held valid is granted within 4 transfers.
- ptr changes only on a transfer, never on idle or stall cycles.
- A single continuous requester is granted every cycle.

Optional Feature:
- Macro: MUX4_RR_ARBITER_PKT_LOCK_EN
- With macro defined:
  - Adds ports in_last (input, 4) and out_last (output, 1; reset 0; registered alongside out).
  - FSM states IDLE and LOCKED, reset to IDLE; lock index register lk, reset 0.
  - IDLE: arbitrate as above. A transfer with in_last[i]=0 moves to LOCKED with lk<=i.
  - LOCKED: winner is forced to lk; in_ready[lk] = load & in_valid[lk]; all other in_ready are 0.
  - LOCKED: a transfer with in_last[lk]=1 returns to IDLE. ptr<=lk on every transfer.
  - A single-beat packet (in_last=1 in IDLE) stays in IDLE.
- Without macro: in_last and out_last do not exist. Every beat is arbitrated independently and there is no FSM.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, sel=0, out=0 immediately without a clock edge. After release with all in_valid set, first grant is sel=0.
- Round robin: WIDTH=8, in0..in3=8'h10,8'h11,8'h12,8'h13, in_valid=4'hF, out_ready=1 -> consecutive out 10,11,12,13,10; sel 0,1,2,3,0; one beat/cycle.
- Backpressure: out_valid=1 with out=8'h11 and out_ready=0 for 3 cycles -> in_ready=4'h0, out=8'h11 held, sel=1 held. Next cycle out_ready=1 -> out=8'h12.
- Wrap: only in2 valid for 2 transfers (sel=2,2). Then in_valid=4'b0110 -> next grants 1 then 2. Wrap order 3,0,1 is skipped correctly.
- Idle: in_valid=0, out_ready=1 after out=8'h13 -> out_valid=0, out/sel hold. ptr unchanged, so the next request of in0 and in3 together grants in0.
- MUX4_RR_ARBITER_PKT_LOCK_EN: in1 sends a 3-beat packet (in_last on beat 3) while in0 and in2 are valid -> sel=1,1,1 with out_last=0,0,1, then sel=2.
